// File: rtl/opb_register_ppc2simulink_sync_if.sv
// OPB slave-side bus bundle for the PPC->fabric control register.
// Bit 0 of every bus vector is the MSB, as on the OPB.
interface opb_register_ppc2simulink_sync_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [0:AW-1]   OPB_ABus;
   logic [0:DW/8-1] OPB_BE;
   logic [0:DW-1]   OPB_DBus;
   logic            OPB_RNW;
   logic            OPB_select;
   logic            OPB_seqAddr;
   logic [0:DW-1]   Sl_DBus;
   logic            Sl_xferAck;
   logic            Sl_errAck;
   logic            Sl_retry;
   logic            Sl_toutSup;

   modport master (
      output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );
   modport slave (
      input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
      output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
   );
endinterface

// File: rtl/opb_register_ppc2simulink_sync.sv
// Software-written control word with byte enables, change strobe and write counter.
// Single clock domain: user logic runs on OPB_Clk.
module opb_register_ppc2simulink_sync #(
   parameter logic [31:0] C_BASEADDR   = 32'h00000000,
   parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter logic [31:0] C_INIT       = 32'h00000000,
   parameter string       C_FAMILY     = "virtex6"
) (
   input  logic                            OPB_Clk,
   input  logic                            OPB_Rst,
   opb_register_ppc2simulink_sync_if.slave bus,
   output logic [31:0]                     user_data_out,
   output logic                            user_data_valid
);
   localparam string UNUSED_FAMILY = C_FAMILY;

   typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

   state_t                  state_q;
   logic                    rnw_q;
   logic [0:3]              be_q;
   logic [C_OPB_AWIDTH-1:0] abus, off_d, off_q;
   logic [C_OPB_DWIDTH-1:0] wdata_q, rdat_d, rdat_q;
   logic [31:0]             ctrl_q, ctrl_d, cnt_q;
   logic                    valid_q, hit_d, ack;
   logic                    unused_seq;

   assign unused_seq = bus.OPB_seqAddr;
   assign abus       = bus.OPB_ABus;
   assign hit_d      = bus.OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
   assign off_d      = abus - C_BASEADDR;

   // Read data is captured at the hit, so a read never sees a same-cycle write.
   always_comb begin
      rdat_d = '0;
      if (off_d == 'h0)      rdat_d = ctrl_q;
      else if (off_d == 'h4) rdat_d = cnt_q;
   end

   // BE[i] covers OPB byte i, which is the i-th most significant user byte.
   always_comb begin
      ctrl_d = ctrl_q;
      for (int i = 0; i < 4; i++)
         if (be_q[i]) ctrl_d[31-8*i -: 8] = wdata_q[31-8*i -: 8];
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q <= IDLE;
         rnw_q   <= 1'b0;
         be_q    <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         rdat_q  <= '0;
         ctrl_q  <= C_INIT;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: if (hit_d) begin
               state_q <= ACK;
               rnw_q   <= bus.OPB_RNW;
               be_q    <= bus.OPB_BE;
               off_q   <= off_d;
               wdata_q <= bus.OPB_DBus;
               rdat_q  <= rdat_d;
            end
            ACK: begin
               state_q <= WAIT;
               if (!rnw_q && off_q == 'h0) begin
                  ctrl_q  <= ctrl_d;
                  valid_q <= (ctrl_d != ctrl_q);
                  cnt_q   <= cnt_q + 32'd1;
               end
            end
            WAIT: if (!bus.OPB_select) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset masks the ack combinationally so a reset in the ACK cycle issues none.
   assign ack            = (state_q == ACK) && !OPB_Rst;
   assign bus.Sl_xferAck = ack;
   assign bus.Sl_DBus    = (ack && rnw_q) ? rdat_q : '0;
   assign bus.Sl_errAck  = 1'b0;
   assign bus.Sl_retry   = 1'b0;
   assign bus.Sl_toutSup = 1'b0;

   assign user_data_out   = ctrl_q;
   assign user_data_valid = valid_q;
endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// Directed bench: stimulus pushes expected ack data and change strobes into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_opb_register_ppc2simulink_sync;
   localparam logic [31:0] BASE = 32'h10000000;
   localparam logic [31:0] HIGH = 32'h100000FF;
   localparam logic [31:0] INIT = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] user_data_out;
   logic        user_data_valid;
   int          n_vec  = 0;
   int          n_fail = 0;
   logic [31:0] ack_q[$];
   logic [31:0] vld_q[$];

   opb_register_ppc2simulink_sync_if bus ();

   opb_register_ppc2simulink_sync #(
      .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32),
      .C_OPB_DWIDTH(32), .C_INIT(INIT), .C_FAMILY("virtex6")
   ) dut (
      .OPB_Clk(clk), .OPB_Rst(rst), .bus(bus),
      .user_data_out(user_data_out), .user_data_valid(user_data_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Monitor: every ack pops one expected read word (writes expect 0);
   // every change strobe pops one expected control word.
   always @(negedge clk) begin
      if (bus.Sl_xferAck) begin
         if (ack_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_ack: got ack at %0t expected none", $time);
         end else chk("ack_data", bus.Sl_DBus, ack_q.pop_front());
      end else if (bus.Sl_DBus !== '0) begin
         n_fail++;
         $display("FAIL idle_dbus: got %08h expected 00000000", bus.Sl_DBus);
      end
      if (bus.Sl_errAck || bus.Sl_retry || bus.Sl_toutSup) begin
         n_fail++;
         $display("FAIL tied_low: got %b%b%b expected 000", bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup);
      end
      if (user_data_valid) begin
         if (vld_q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_valid: got pulse with %08h expected none", user_data_out);
         end else chk("valid_word", user_data_out, vld_q.pop_front());
      end
   end

   // One transfer holding select for 'hold' cycles (at least until the ack).
   task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                       input logic [31:0] data, input int hold);
      bit got = 0;
      int lat = 0;
      @(posedge clk); #1;
      bus.OPB_ABus = addr; bus.OPB_RNW = rnw; bus.OPB_BE = be;
      bus.OPB_DBus = data; bus.OPB_select = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.Sl_xferAck && !got) begin got = 1; lat = c; end
         @(posedge clk); #1;
         if (c >= hold) bus.OPB_select = 1'b0;
         if (got && c >= hold) break;
      end
      bus.OPB_select = 1'b0;
      if (!got) begin
         n_vec++; n_fail++;
         $display("FAIL ack_timeout: got no ack expected one at addr %08h", addr);
      end else chk("ack_latency", lat, 2);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
      ack_q.push_back(exp);
      xfer(addr, 1'b1, 4'b1111, 32'h0, 2);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [0:3] be, input logic [31:0] data,
                     input logic [31:0] exp_word, input bit pulse, input int hold);
      ack_q.push_back(32'h0);
      if (pulse) vld_q.push_back(exp_word);
      xfer(addr, 1'b0, be, data, hold);
      @(negedge clk);
      chk("user_data_out", user_data_out, exp_word);
   endtask

   initial begin
      int acks;
      bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
      bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_user_data", user_data_out, INIT);
      chk("rst_valid", user_data_valid, 0);
      chk("rst_ack", bus.Sl_xferAck, 0);
      chk("rst_dbus", bus.Sl_DBus, 0);
      @(posedge clk); #1 rst = 1'b0;
      rd(BASE + 4, 32'h0);

      wr(BASE, 4'b1111, 32'h12345678, 32'h12345678, 1, 2);
      rd(BASE + 4, 32'h1);
      wr(BASE, 4'b0101, 32'hAABBCCDD, 32'h12BB56DD, 1, 2);
      wr(BASE, 4'b1111, 32'h12BB56DD, 32'h12BB56DD, 0, 2);
      rd(BASE + 4, 32'h3);
      rd(BASE, 32'h12BB56DD);
      wr(BASE, 4'b0000, 32'hFFFFFFFF, 32'h12BB56DD, 0, 2);
      rd(BASE + 4, 32'h4);

      // long select: a second ack would hit an empty queue
      rd(BASE, 32'h12BB56DD);
      ack_q.push_back(32'h12BB56DD);
      xfer(BASE, 1'b1, 4'b1111, 32'h0, 6);

      // out-of-window address: no ack at all
      acks = 0;
      @(posedge clk); #1;
      bus.OPB_ABus = HIGH + 4; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
      repeat (4) begin @(negedge clk); if (bus.Sl_xferAck) acks++; end
      @(posedge clk); #1 bus.OPB_select = 1'b0;
      chk("miss_acks", acks, 0);

      wr(BASE + 8, 4'b1111, 32'h0, 32'h12BB56DD, 0, 2);
      rd(BASE + 8, 32'h0);
      rd(BASE + 4, 32'h4);

      // select dropped during ACK: ack and write still complete
      wr(BASE, 4'b1111, 32'h00000001, 32'h00000001, 1, 1);
      rd(BASE + 4, 32'h5);

      // reset in the ACK cycle of a write
      @(posedge clk); #1;
      bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b0; bus.OPB_BE = 4'b1111;
      bus.OPB_DBus = 32'hFFFFFFFF; bus.OPB_select = 1'b1;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ack", bus.Sl_xferAck, 0);
      @(posedge clk); #1 rst = 1'b0; bus.OPB_select = 1'b0;
      @(negedge clk);
      chk("rst_in_ack_word", user_data_out, INIT);
      rd(BASE + 4, 32'h0);

      // counter wrap
      @(posedge clk); #1 force dut.cnt_q = 32'hFFFFFFFF;
      @(posedge clk); #1 release dut.cnt_q;
      rd(BASE + 4, 32'hFFFFFFFF);
      wr(BASE, 4'b1111, INIT, INIT, 0, 2);
      rd(BASE + 4, 32'h0);

      repeat (4) @(posedge clk);
      chk("ack_queue_left", ack_q.size(), 0);
      chk("valid_queue_left", vld_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
